bcd_serial_addsub: RTL

//  Digit-serial N-digit BCD adder/subtractor. Sits downstream of the per-digit

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adder.sv | 26 ++
 rtl/bcd_serial_addsub.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD add/subtract block.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RECOMP,
        DONE
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIX  = 4'd6;

    // A nibble is a legal BCD digit when it lies in 0..9.
    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit of addition: x + y + cin with decimal (>9) correction.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] sum;

    // Binary sum, then add six and raise carry when it leaves the decimal range.
    always_comb begin
        sum = {1'b0, x} + {1'b0, y} + {4'b0, cin};
        if (sum > 5'd9) begin
            digit = sum[3:0] + BCD_FIX;
            cout  = 1'b1;
        end else begin
            digit = sum[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor, LSD first, with tens'-complement recompletion
// of negative differences so that the result is always a magnitude.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NDIGITS-1:0] a,
    input  logic [4*NDIGITS-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NDIGITS-1:0] result,
    output logic                 carry_out,
    output logic                 negative,
    output logic                 invalid
);

    localparam int W  = 4 * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_t          state, state_nxt;
    logic [W-1:0]    a_sr, b_sr;
    logic            sub_r;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            last;
    logic            any_bad;
    logic [3:0]      x, y, dig;
    logic            dcout;

    assign last = (idx == IW'(NDIGITS - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Screen the live operands so a bad digit is known at the capture edge.
    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4]))
                any_bad = 1'b1;
        end
    end

    // Operand mux: RUN adds A to B (or B's nines' complement); RECOMP takes the
    // nines' complement of the partial result, so the +1 carry yields 10^N - R.
    always_comb begin
        if (state == RECOMP) begin
            x = BCD_NINE - result[3:0];
            y = 4'd0;
        end else begin
            x = a_sr[3:0];
            y = sub_r ? (BCD_NINE - b_sr[3:0]) : b_sr[3:0];
        end
    end

    bcd_digit_adder u_dig (
        .x     (x),
        .y     (y),
        .cin   (carry),
        .digit (dig),
        .cout  (dcout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a subtraction that ends without carry borrowed, so recomplement.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = any_bad ? DONE : RUN;
            RUN:     if (last)  state_nxt = (!sub_r || dcout) ? DONE : RECOMP;
            RECOMP:  if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand shifters, result shifter (new digit enters at the top),
    // digit counter, carry and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sub_r     <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            negative  <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr      <= a;
                        b_sr      <= b;
                        sub_r     <= sub;
                        carry     <= sub;
                        idx       <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        negative  <= 1'b0;
                        invalid   <= any_bad;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 4;
                    b_sr   <= b_sr >> 4;
                    result <= (result >> 4) | (W'(dig) << (W - 4));
                    carry  <= dcout;
                    idx    <= last ? '0 : idx + IW'(1);
                    if (last) begin
                        if (!sub_r) begin
                            carry_out <= dcout;
                        end else if (!dcout) begin
                            negative <= 1'b1;
                            carry    <= 1'b1;
                        end
                    end
                end
                RECOMP: begin
                    result <= (result >> 4) | (W'(dig) << (W - 4));
                    carry  <= dcout;
                    idx    <= last ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
